// File: rtl/video_timing_gen_if.sv
// ============================================================================
// Module  : video_timing_gen_if
// Brief   : Raster timing bundle (syncs, data enable, pixel coords, strobes).
// Revision: 1.0
// ============================================================================
`default_nettype none

interface video_timing_gen_if;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [11:0] x;
    logic [10:0] y;
    logic        line_start;
    logic        frame_start;

    modport master (
        output hsync, vsync, de, x, y, line_start, frame_start
    );

    modport slave (
        input  hsync, vsync, de, x, y, line_start, frame_start
    );
endinterface

`default_nettype wire

// File: rtl/video_timing_gen.sv
// ============================================================================
// Module  : video_timing_gen
// Brief   : Parameterised raster timing generator (720p60 defaults).
// Revision: 1.0
// ============================================================================
`default_nettype none

module video_timing_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit SYNC_POL = 1'b1,
    parameter int LATENCY  = 0
) (
    input  wire logic          clk,
    input  wire logic          rst,
    video_timing_gen_if.master vid
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_W       = 28;

    generate
        if ((c_H_TOTAL > 4095) || (c_V_TOTAL > 2047) || (LATENCY < 0) || (LATENCY > 7)) begin : g_bad_cfg
            $error("video_timing_gen: illegal timing or LATENCY parameters");
        end
    endgenerate

    localparam logic [11:0] c_H_LAST     = 12'(c_H_TOTAL - 1);
    localparam logic [11:0] c_H_ACT      = 12'(H_ACTIVE);
    localparam logic [11:0] c_HS_START   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] c_HS_END     = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] c_V_LAST     = 11'(c_V_TOTAL - 1);
    localparam logic [10:0] c_V_ACT      = 11'(V_ACTIVE);
    localparam logic [10:0] c_VS_START   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] c_VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [c_W-1:0] c_RST_VEC = {!SYNC_POL, !SYNC_POL, 26'd0};

    logic [11:0]    r_h_cnt;
    logic [10:0]    r_v_cnt;
    logic [c_W-1:0] r_pipe [0:LATENCY];

    logic           w_de;
    logic           w_hs;
    logic           w_vs;
    logic           w_ls;
    logic           w_fs;
    logic [c_W-1:0] w_dec;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == c_H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + 11'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 12'd1;
        end
    end

    // vsync decodes only v_cnt, which changes solely on the h_cnt wrap.
    always_comb begin
        w_de  = (r_h_cnt < c_H_ACT) && (r_v_cnt < c_V_ACT);
        w_hs  = ((r_h_cnt >= c_HS_START) && (r_h_cnt < c_HS_END)) ? SYNC_POL : !SYNC_POL;
        w_vs  = ((r_v_cnt >= c_VS_START) && (r_v_cnt < c_VS_END)) ? SYNC_POL : !SYNC_POL;
        w_ls  = (r_h_cnt == 12'd0);
        w_fs  = (r_h_cnt == 12'd0) && (r_v_cnt == 11'd0);
        w_dec = {w_hs, w_vs, w_de,
                 (w_de ? r_h_cnt : 12'd0),
                 (w_de ? r_v_cnt : 11'd0),
                 w_ls, w_fs};
    end

    // Reset flushes every stage so no pre-reset pulse leaks out afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= LATENCY; i++) begin
                r_pipe[i] <= c_RST_VEC;
            end
        end else begin
            r_pipe[0] <= w_dec;
            for (int i = 1; i <= LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign vid.hsync       = r_pipe[LATENCY][27];
    assign vid.vsync       = r_pipe[LATENCY][26];
    assign vid.de          = r_pipe[LATENCY][25];
    assign vid.x           = r_pipe[LATENCY][24:13];
    assign vid.y           = r_pipe[LATENCY][12:2];
    assign vid.line_start  = r_pipe[LATENCY][1];
    assign vid.frame_start = r_pipe[LATENCY][0];

endmodule

`default_nettype wire

// File: tb/tb_video_timing_gen.sv
// ============================================================================
// Module  : tb_video_timing_gen
// Brief   : Scoreboard bench for two small raster configurations.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_video_timing_gen;

    localparam int A_HA = 4,  A_HF = 1, A_HS = 1, A_HB = 1;
    localparam int A_VA = 2,  A_VF = 1, A_VS = 1, A_VB = 1;
    localparam int A_LAT = 0;
    localparam bit A_POL = 1'b1;

    localparam int B_HA = 16, B_HF = 3, B_HS = 4, B_HB = 5;
    localparam int B_VA = 6,  B_VF = 2, B_VS = 2, B_VB = 3;
    localparam int B_LAT = 3;
    localparam bit B_POL = 1'b0;

    localparam int A_FRAME = (A_HA+A_HF+A_HS+A_HB) * (A_VA+A_VF+A_VS+A_VB);
    localparam int B_FRAME = (B_HA+B_HF+B_HS+B_HB) * (B_VA+B_VF+B_VS+B_VB);

    logic clk = 1'b0;
    logic rst;

    video_timing_gen_if ifa ();
    video_timing_gen_if ifb ();

    video_timing_gen #(
        .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
        .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
        .SYNC_POL(A_POL), .LATENCY(A_LAT)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .vid (ifa)
    );

    video_timing_gen #(
        .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
        .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
        .SYNC_POL(B_POL), .LATENCY(B_LAT)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .vid (ifb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [27:0] a;
        logic [27:0] b;
        bit          r;
        int          d;
    } item_t;

    item_t q[$];
    int    checks   = 0;
    int    failures = 0;

    // Expected pin value given d clock edges since the most recent reset edge.
    function automatic logic [27:0] ref_out(
        input int ha, input int hf, input int hs, input int hb,
        input int va, input int vf, input int vs, input int vb,
        input int lat, input bit pol, input int d);
        int  ht, vt, pos, h, v;
        bit  de, hsy, vsy;
        if (d <= lat) return {~pol, ~pol, 26'd0};
        ht  = ha + hf + hs + hb;
        vt  = va + vf + vs + vb;
        pos = (d - lat - 1) % (ht * vt);
        h   = pos % ht;
        v   = pos / ht;
        de  = (h < ha) && (v < va);
        hsy = (h >= ha + hf && h < ha + hf + hs) ? pol : ~pol;
        vsy = (v >= va + vf && v < va + vf + vs) ? pol : ~pol;
        return {hsy, vsy, de,
                (de ? 12'(h) : 12'd0),
                (de ? 11'(v) : 11'd0),
                (h == 0), (h == 0 && v == 0)};
    endfunction

    // Stimulus: reset, a long clean run, then random mid-frame reset pulses.
    initial begin
        int k, r, hold;
        rst  = 1'b1;
        k    = 0;
        r    = 0;
        hold = 0;
        for (int n = 0; n < 3200; n++) begin
            item_t it;
            @(posedge clk);
            k++;
            if (rst) r = k;
            it.a = ref_out(A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB, A_LAT, A_POL, k - r);
            it.b = ref_out(B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, B_LAT, B_POL, k - r);
            it.r = rst;
            it.d = k - r;
            q.push_back(it);
            #1;
            if (n < 4) begin
                rst = 1'b1;
            end else if (hold > 0) begin
                rst = 1'b1;
                hold--;
            end else if (n > 1000 && $urandom_range(0, 249) == 0) begin
                rst  = 1'b1;
                hold = $urandom_range(0, 4);
            end else begin
                rst = 1'b0;
            end
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d items left, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Monitor: pops one expectation per clock and checks both DUTs.
    initial begin
        int       cyc = 0;
        int       a_prev = -1, b_prev = -1;
        bit       pat_done = 1'b0;
        logic [6:0] pat = '0;
        forever begin
            item_t       it;
            logic [27:0] act_a, act_b;
            @(negedge clk);
            cyc++;
            if (q.size() == 0) continue;
            it    = q.pop_front();
            act_a = {ifa.hsync, ifa.vsync, ifa.de, ifa.x, ifa.y, ifa.line_start, ifa.frame_start};
            act_b = {ifb.hsync, ifb.vsync, ifb.de, ifb.x, ifb.y, ifb.line_start, ifb.frame_start};

            checks++;
            if (act_a !== it.a) begin
                failures++;
                $display("FAIL sb_A cyc=%0d d=%0d got=%h want=%h", cyc, it.d, act_a, it.a);
            end
            checks++;
            if (act_b !== it.b) begin
                failures++;
                $display("FAIL sb_B cyc=%0d d=%0d got=%h want=%h", cyc, it.d, act_b, it.b);
            end

            if (it.r) begin
                a_prev = -1;
                b_prev = -1;
            end
            if (ifa.frame_start === 1'b1) begin
                if (a_prev >= 0) begin
                    checks++;
                    if (cyc - a_prev != A_FRAME) begin
                        failures++;
                        $display("FAIL period_A got=%0d want=%0d", cyc - a_prev, A_FRAME);
                    end
                end
                a_prev = cyc;
            end
            if (ifb.frame_start === 1'b1) begin
                if (b_prev >= 0) begin
                    checks++;
                    if (cyc - b_prev != B_FRAME) begin
                        failures++;
                        $display("FAIL period_B got=%0d want=%0d", cyc - b_prev, B_FRAME);
                    end
                end
                b_prev = cyc;
            end

            if (!pat_done && it.d >= 1 && it.d <= 7) begin
                pat = {pat[5:0], ifa.de};
                if (it.d == 7) begin
                    pat_done = 1'b1;
                    checks++;
                    if (pat !== 7'b1111000) begin
                        failures++;
                        $display("FAIL de_pattern_A got=%b want=1111000", pat);
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 1280, active pixels per line.
REQ-002 Parameter H_FP, default 110, horizontal front porch in clocks.
REQ-003 Parameter H_SYNC, default 40, hsync width in clocks.
REQ-004 Parameter H_BP, default 220, horizontal back porch in clocks.
REQ-005 Parameter V_ACTIVE, default 720, active lines per frame.
REQ-006 Parameter V_FP, default 5, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 5, vsync width in lines.
REQ-008 Parameter V_BP, default 20, vertical back porch in lines.
REQ-009 Parameter SYNC_POL, default 1, 1 = sync pulses active-high, 0 = active-low.
REQ-010 Parameter LATENCY, default 0, extra register stages (0..7) on all outputs.
REQ-011 clk  input  1  pixel clock (74.25 MHz for 720p60); sole clock of the block.
REQ-012 rst  input  1  synchronous, active-high reset.
REQ-013 hsync  output  1  horizontal sync, polarity per SYNC_POL.
REQ-014 vsync  output  1  vertical sync, polarity per SYNC_POL.
REQ-015 de  output  1  data enable, high during active pixels.
REQ-016 x  output  12  active pixel column; 0 when de low.
REQ-017 y  output  11  active line number; 0 when de low.
REQ-018 line_start  output  1  one-clock pulse on the first clock of each line (h_cnt = 0).
REQ-019 frame_start  output  1  one-clock pulse on the first clock of each frame (h_cnt = 0, v_cnt = 0).

Function
REQ-020 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP; 720p defaults give 1650 x 750.
REQ-021 Internal h_cnt (12 bits) increments every clock, wraps from H_TOTAL-1 to 0.
REQ-022 Internal v_cnt (11 bits) increments when h_cnt wraps, wraps from V_TOTAL-1 to 0 at the same clock as h_cnt wraps.
REQ-023 Line order: active [0, H_ACTIVE), front porch, sync, back porch; frame order identical for lines.
REQ-024 Horizontal sync asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (1390..1429 default).
REQ-025 Vertical sync asserted for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (725..729 default), changing only at h_cnt = 0.
REQ-026 de = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE); x = h_cnt, y = v_cnt when de, else 0.
REQ-027 All outputs decoded from counters into one output register stage, then LATENCY further stages; total latency counter-to-pin = 1+LATENCY clocks, identical for every output.
REQ-028 Sync outputs in inactive state equal !SYNC_POL; active state equals SYNC_POL.
REQ-029 Parameter sums exceeding counter widths (H_TOTAL > 4095 or V_TOTAL > 2047) or LATENCY > 7 are illegal; elaboration shall fail.

Reset
REQ-030 While rst high: h_cnt = v_cnt = 0; every output stage holds de = 0, x = 0, y = 0, line_start = 0, frame_start = 0, hsync = vsync = !SYNC_POL.
REQ-031 On the first rising edge with rst low, counters (0,0) are decoded; after 1+LATENCY edges frame_start = line_start = de = 1, x = 0, y = 0.
REQ-032 rst asserted mid-frame takes effect at the next edge, discarding the partial frame; no partial sync pulse is held beyond the reset edge.

Verification
REQ-033 Defaults, LATENCY=0, release reset, run 2 frames -> frame_start pulses exactly 1,237,500 clocks apart; line_start every 1650 clocks; 750 line_start pulses per frame.
REQ-034 Defaults, one frame -> de high for exactly 921,600 clocks, 1280 per active line; x runs 0..1279, y runs 0..719; de low on lines 720..749.
REQ-035 Defaults, SYNC_POL=1 -> hsync high 40 clocks starting 1390 clocks after line_start; vsync high for 8250 clocks starting 725 x 1650 = 1,196,250 clocks after frame_start, edges coincident with line_start.
REQ-036 SYNC_POL=0, LATENCY=3 -> all waveforms identical to REQ-035 but syncs inverted and every output shifted 3 clocks later; during reset hsync = vsync = 1.
REQ-037 Assert rst for 4 clocks at h_cnt=500, v_cnt=300 -> outputs at reset value from the next edge; first post-reset frame_start after 1+LATENCY clocks; frame period thereafter 1,237,500.
REQ-038 Small config H=4/1/1/1, V=2/1/1/1, LATENCY=0 -> 7-clock lines, 5-line frames (35 clocks); de pattern 1111000 on lines 0..1, hsync on h_cnt=5, vsync on line 3.
